// File: rtl/chip8_decode_pipe.sv
// Handshaked CHIP-8 / SUPER-CHIP decoder with a registered output stage and a 1-entry skid buffer.
// Optional saturating illegal-entry counter is enabled with macro DECODE_ILLEGAL_CNT_EN.
module chip8_decode_pipe #(
  parameter int ADDR_W = 12,
  parameter int OPC_W  = 6,
  parameter int SCHIP  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  decode,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic [3:0]        nib,
`ifdef DECODE_ILLEGAL_CNT_EN
  output logic [15:0]       illegal_cnt,
`endif
  output logic [7:0]        val
);

  typedef struct packed {
    logic [15:0]       ins;
    logic [ADDR_W-1:0] pc;
    logic [5:0]        cls;
  } entry_t;

  entry_t out_q, out_d, skid_q, skid_d, in_entry;
  logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

  function automatic logic [5:0] decode_class(input logic [15:0] ins);
    logic [5:0] c;
    logic       sc;
    sc = (SCHIP != 0);
    c  = 6'd0;
    case (ins[15:12])
      4'h0: begin
        if (ins == 16'h00E0)                                c = 6'd1;
        else if (ins == 16'h00EE)                           c = 6'd2;
        else if (sc && ins[15:4] == 12'h00C)                c = 6'd36;
        else if (sc && ins[15:8] == 8'h00 && ins[7:0] >= 8'hFB)
          c = 6'd37 + 6'(ins[7:0] - 8'hFB);
        else                                                c = 6'd31;
      end
      4'h1: c = 6'd3;
      4'h2: c = 6'd4;
      4'h3: c = 6'd5;
      4'h4: c = 6'd6;
      4'h5: c = (ins[3:0] == 4'h0) ? 6'd7 : 6'd0;
      4'h6: c = 6'd8;
      4'h7: c = 6'd9;
      4'h8: begin
        case (ins[3:0])
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: c = 6'd10 + {2'b00, ins[3:0]};
          4'hE:    c = 6'd18;
          default: c = 6'd0;
        endcase
      end
      4'h9: c = (ins[3:0] == 4'h0) ? 6'd19 : 6'd0;
      4'hA: c = 6'd20;
      4'hB: c = 6'd21;
      4'hC: c = 6'd22;
      4'hD: c = (sc && ins[3:0] == 4'h0) ? 6'd42 : 6'd23;
      4'hE: begin
        case (ins[7:0])
          8'h9E:   c = 6'd24;
          8'hA1:   c = 6'd25;
          default: c = 6'd0;
        endcase
      end
      4'hF: begin
        case (ins[7:0])
          8'h07:   c = 6'd26;
          8'h0A:   c = 6'd27;
          8'h15:   c = 6'd28;
          8'h18:   c = 6'd29;
          8'h1E:   c = 6'd30;
          8'h29:   c = 6'd32;
          8'h33:   c = 6'd33;
          8'h55:   c = 6'd34;
          8'h65:   c = 6'd35;
          8'h30:   c = sc ? 6'd43 : 6'd0;
          8'h75:   c = sc ? 6'd44 : 6'd0;
          8'h85:   c = sc ? 6'd45 : 6'd0;
          default: c = 6'd0;
        endcase
      end
      default: c = 6'd0;
    endcase
    return c;
  endfunction

  always_comb begin
    in_entry.ins = instruction;
    in_entry.pc  = in_pc;
    in_entry.cls = decode_class(instruction);
  end

  // Skid only fills when the output stage is held; it always drains before new input is taken.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_d      = '0;
      out_vld_d  = 1'b0;
      skid_d     = '0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_ready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_valid) begin
        out_d     = in_entry;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_valid && !skid_vld_q) begin
      skid_d     = in_entry;
      skid_vld_d = 1'b1;
    end else begin
      skid_vld_d = skid_vld_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign decode    = OPC_W'(out_q.cls);
  assign illegal   = out_vld_q && (out_q.cls == 6'd0);
  assign pc_out    = out_q.pc;
  assign addr_out  = ADDR_W'(out_q.ins[11:0]);
  assign x         = out_q.ins[11:8];
  assign y         = out_q.ins[7:4];
  assign nib       = out_q.ins[3:0];
  assign val       = out_q.ins[7:0];

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && out_vld_q && out_ready && out_q.cls == 6'd0 && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_chip8_decode_pipe.sv
// Randomised + directed bench: two decoder instances (CHIP-8 only and SUPER-CHIP) checked against
// a table-driven opcode model and a queue model of the two-entry pipe.
module tb_chip8_decode_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] instruction;
  logic [11:0] in_pc;

  logic        rdy0, vld0, ill0, rdy1, vld1, ill1;
  logic [5:0]  dec0, dec1;
  logic [11:0] pc0, pc1, addr0, addr1;
  logic [3:0]  x0, y0, n0, x1, y1, n1;
  logic [7:0]  v0, v1;
`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] cnt0, cnt1;
  int          mcnt0 = 0, mcnt1 = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chip8_decode_pipe #(.ADDR_W(12), .OPC_W(6), .SCHIP(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .instruction(instruction), .in_pc(in_pc), .out_valid(vld0), .out_ready(out_ready),
    .decode(dec0), .illegal(ill0), .pc_out(pc0), .addr_out(addr0), .x(x0), .y(y0), .nib(n0),
`ifdef DECODE_ILLEGAL_CNT_EN
    .illegal_cnt(cnt0),
`endif
    .val(v0));

  chip8_decode_pipe #(.ADDR_W(12), .OPC_W(6), .SCHIP(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .instruction(instruction), .in_pc(in_pc), .out_valid(vld1), .out_ready(out_ready),
    .decode(dec1), .illegal(ill1), .pc_out(pc1), .addr_out(addr1), .x(x1), .y(y1), .nib(n1),
`ifdef DECODE_ILLEGAL_CNT_EN
    .illegal_cnt(cnt1),
`endif
    .val(v1));

  typedef struct {
    logic [15:0] mask;
    logic [15:0] match;
    int          cls;
    bit          sc_only;
  } pat_t;
  pat_t pats[$];

  typedef struct {
    logic [15:0] ins;
    logic [11:0] pc;
  } ent_t;
  ent_t q[$];

  function automatic void add(logic [15:0] m, logic [15:0] k, int c, bit s);
    pat_t p;
    p.mask = m; p.match = k; p.cls = c; p.sc_only = s;
    pats.push_back(p);
  endfunction

  // First matching pattern wins; unmatched opcodes are illegal (class 0).
  function automatic int ref_class(logic [15:0] ins, bit sc);
    foreach (pats[i])
      if ((!pats[i].sc_only || sc) && ((ins & pats[i].mask) == pats[i].match)) return pats[i].cls;
    return 0;
  endfunction

  task automatic build_table();
    add(16'hFFFF, 16'h00E0, 1, 0);  add(16'hFFFF, 16'h00EE, 2, 0);
    add(16'hFFF0, 16'h00C0, 36, 1);
    for (int i = 0; i < 5; i++) add(16'hFFFF, 16'h00FB + 16'(i), 37 + i, 1);
    add(16'hF000, 16'h0000, 31, 0);
    add(16'hF000, 16'h1000, 3, 0);  add(16'hF000, 16'h2000, 4, 0);
    add(16'hF000, 16'h3000, 5, 0);  add(16'hF000, 16'h4000, 6, 0);
    add(16'hF00F, 16'h5000, 7, 0);  add(16'hF000, 16'h6000, 8, 0);
    add(16'hF000, 16'h7000, 9, 0);
    for (int i = 0; i < 8; i++) add(16'hF00F, 16'h8000 + 16'(i), 10 + i, 0);
    add(16'hF00F, 16'h800E, 18, 0); add(16'hF00F, 16'h9000, 19, 0);
    add(16'hF000, 16'hA000, 20, 0); add(16'hF000, 16'hB000, 21, 0);
    add(16'hF000, 16'hC000, 22, 0); add(16'hF00F, 16'hD000, 42, 1);
    add(16'hF000, 16'hD000, 23, 0);
    add(16'hF0FF, 16'hE09E, 24, 0); add(16'hF0FF, 16'hE0A1, 25, 0);
    add(16'hF0FF, 16'hF007, 26, 0); add(16'hF0FF, 16'hF00A, 27, 0);
    add(16'hF0FF, 16'hF015, 28, 0); add(16'hF0FF, 16'hF018, 29, 0);
    add(16'hF0FF, 16'hF01E, 30, 0); add(16'hF0FF, 16'hF029, 32, 0);
    add(16'hF0FF, 16'hF033, 33, 0); add(16'hF0FF, 16'hF055, 34, 0);
    add(16'hF0FF, 16'hF065, 35, 0); add(16'hF0FF, 16'hF030, 43, 1);
    add(16'hF0FF, 16'hF075, 44, 1); add(16'hF0FF, 16'hF085, 45, 1);
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [15:0] ins;
    check("out_valid0", 64'(vld0), 64'(q.size() > 0));
    check("out_valid1", 64'(vld1), 64'(q.size() > 0));
    check("in_ready0", 64'(rdy0), 64'(q.size() < 2));
    check("in_ready1", 64'(rdy1), 64'(q.size() < 2));
    if (q.size() > 0) begin
      ins = q[0].ins;
      check("decode0", 64'(dec0), 64'(ref_class(ins, 1'b0)));
      check("decode1", 64'(dec1), 64'(ref_class(ins, 1'b1)));
      check("illegal0", 64'(ill0), 64'(ref_class(ins, 1'b0) == 0));
      check("illegal1", 64'(ill1), 64'(ref_class(ins, 1'b1) == 0));
      check("pc_out", {pc0, pc1}, {q[0].pc, q[0].pc});
      check("addr_out", {addr0, addr1}, {ins[11:0], ins[11:0]});
      check("xyn", {x0, y0, n0, x1, y1, n1}, {ins[11:8], ins[7:4], ins[3:0], ins[11:8], ins[7:4], ins[3:0]});
      check("val", {v0, v1}, {ins[7:0], ins[7:0]});
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    check("illegal_cnt0", 64'(cnt0), 64'(mcnt0));
    check("illegal_cnt1", 64'(cnt1), 64'(mcnt1));
`endif
  endtask

  // Called at a falling edge: check, drive, advance the model across the next rising edge.
  task automatic step(input logic v, input logic [15:0] ins, input logic [11:0] pc,
                      input logic ordy, input logic fl);
    bit   acc, fire;
    ent_t e;
    compare_outputs();
    in_valid = v; instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    acc  = v && (q.size() < 2) && !fl;
    fire = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (fire) begin
`ifdef DECODE_ILLEGAL_CNT_EN
        if (ref_class(q[0].ins, 1'b0) == 0 && mcnt0 < 65535) mcnt0++;
        if (ref_class(q[0].ins, 1'b1) == 0 && mcnt1 < 65535) mcnt1++;
`endif
        void'(q.pop_front());
      end
      if (acc) begin
        e.ins = ins; e.pc = pc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 12'h000, ordy, 1'b0);
  endtask

  initial begin
    logic [15:0] ins;
    int          k;
    build_table();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = 16'h0000; in_pc = 12'h000;
    repeat (3) @(negedge clk);
    check("reset_valid", {vld0, vld1}, 2'b00);
    check("reset_ready", {rdy0, rdy1}, 2'b11);
    check("reset_data", {dec0, ill0, pc0, addr0, x0, y0, n0, v0},
          {6'd0, 1'b0, 12'h000, 12'h000, 4'h0, 4'h0, 4'h0, 8'h00});
    check("reset_data1", {dec1, pc1, addr1, v1}, {6'd0, 12'h000, 12'h000, 8'h00});
    rst = 1'b1;
    @(negedge clk);

    // Full-rate stream
    step(1'b1, 16'h00E0, 12'h200, 1'b1, 1'b0);
    step(1'b1, 16'h00EE, 12'h202, 1'b1, 1'b0);
    step(1'b1, 16'h1234, 12'h204, 1'b1, 1'b0);
    step(1'b1, 16'h6A5F, 12'h206, 1'b1, 1'b0);
    step(1'b1, 16'hD125, 12'h208, 1'b1, 1'b0);
    step(1'b1, 16'h8120, 12'h20A, 1'b1, 1'b0);
    step(1'b1, 16'hC3F0, 12'h20C, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Backpressure: third word is held until accepted
    step(1'b1, 16'h7105, 12'h300, 1'b0, 1'b0);
    step(1'b1, 16'h7206, 12'h302, 1'b0, 1'b0);
    step(1'b1, 16'h7307, 12'h304, 1'b0, 1'b0);
    step(1'b1, 16'h7307, 12'h304, 1'b1, 1'b0);
    step(1'b1, 16'h7307, 12'h304, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Flush with both stages occupied
    step(1'b1, 16'hA111, 12'h400, 1'b0, 1'b0);
    step(1'b1, 16'hA222, 12'h402, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 12'h000, 1'b0, 1'b0);
    step(1'b1, 16'hA333, 12'h404, 1'b0, 1'b1);
    step(1'b1, 16'hA444, 12'h406, 1'b1, 1'b0);
    idle(2, 1'b1);

    // SUPER-CHIP differences and illegal patterns
    step(1'b1, 16'h00FF, 12'h500, 1'b1, 1'b0);
    step(1'b1, 16'hF075, 12'h502, 1'b1, 1'b0);
    step(1'b1, 16'hD120, 12'h504, 1'b1, 1'b0);
    step(1'b1, 16'h00C7, 12'h506, 1'b1, 1'b0);
    step(1'b1, 16'h5121, 12'h508, 1'b1, 1'b0);
    step(1'b1, 16'hE1FF, 12'h50A, 1'b1, 1'b0);
    step(1'b1, 16'h8F0F, 12'h50C, 1'b1, 1'b0);
    step(1'b1, 16'h8ABE, 12'h50E, 1'b1, 1'b0);
    step(1'b1, 16'h9AB1, 12'h510, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Random traffic: half the opcodes are drawn from the table with random fields
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        k   = $urandom_range(0, pats.size() - 1);
        ins = pats[k].match | (16'($urandom) & ~pats[k].mask);
      end else begin
        ins = 16'($urandom);
      end
      step(1'($urandom_range(0, 3) != 0), ins, 12'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    idle(3, 1'b1);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chip8_decode_pipe.md
Name: chip8_decode_pipe

Overview:
Parametrised, handshaked successor to the single-cycle CHIP-8 opcode decoder. Accepts 16-bit instructions plus a PC tag from fetch via valid/ready. Emits decoded opcode class, operand fields and an illegal flag to the execute unit through a registered output stage with a 1-entry skid buffer, so full throughput is sustained under backpressure. Optional SUPER-CHIP opcode set, flush for jumps and skips, full fix-up of operand extraction (8xy0 yields y; Cxkk yields x/val).

Parameters:
ADDR_W, 12, width of addr_out and PC tag
OPC_W, 6, width of decode class output (must be >= 6)
SCHIP, 0, 1 = decode SUPER-CHIP extensions; 0 = CHIP-8 only

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
flush  in  1  discard all held/in-flight entries this cycle
in_valid  in  1  instruction valid
in_ready  out  1  decoder can accept
instruction  in  16  opcode, MSB first
in_pc  in  ADDR_W  PC of instruction
out_valid  out  1  decoded entry valid
out_ready  in  1  execute accepts entry
decode  out  OPC_W  opcode class (table below)
illegal  out  1  opcode not in active set
pc_out  out  ADDR_W  tag passthrough
addr_out  out  ADDR_W  nnn, zero-extended
x  out  4  instruction[11:8]
y  out  4  instruction[7:4]
nib  out  4  instruction[3:0]
val  out  8  instruction[7:0]

Behaviour:
- Reset (rst=0, async): out_valid=0, skid empty, in_ready=1, all data outputs 0.
- Class codes: 0 illegal; 1 CLS 00E0; 2 RET 00EE; 3 JP 1nnn; 4 CALL 2nnn; 5 SE Vx,kk; 6 SNE Vx,kk; 7 SE Vx,Vy (5xy0 only); 8 LD Vx,kk; 9 ADD Vx,kk; 10-18 8xy0..8xy7,8xyE in order LD,OR,AND,XOR,ADD,SUB,SHR,SUBN,SHL; 19 SNE Vx,Vy (9xy0 only); 20 LD I,nnn; 21 JP V0,nnn; 22 RND Cxkk; 23 DRW Dxyn; 24 SKP Ex9E; 25 SKNP ExA1; 26 Fx07; 27 Fx0A; 28 Fx15; 29 Fx18; 30 Fx1E; 31 SYS 0nnn (other 0-group); 32 Fx29; 33 Fx33; 34 Fx55; 35 Fx65.
- SCHIP=1 adds: 36 SCD 00Cn; 37 00FB; 38 00FC; 39 00FD; 40 00FE; 41 00FF; 42 DRW16 Dxy0; 43 Fx30; 44 Fx75; 45 Fx85. With SCHIP=0 these decode as SYS (0-group), DRW n=0, or illegal (F-group).
- Illegal: decode=0, illegal=1; 5xyN/9xyN with N!=0, 8xy{8-D,F}, E-group not 9E/A1, unlisted F-group. Illegal entries still flow through the pipe.
- x, y, nib, val, addr_out always carry raw fields regardless of class.
- Latency: entry accepted at edge N appears with out_valid=1 after edge N (1 cycle).
- Handshake: transfer when valid&&ready. in_ready = !skid_full (registered). If output stage holds an entry and out_ready=0 while an input is accepted, that input goes to the skid buffer; skid drains into the output stage on the next out_ready. Order strictly preserved; no drop, no duplicate.
- Simultaneous out-transfer and in-transfer with skid empty: new entry replaces output entry, out_valid stays 1.
- Outputs stable while out_valid=1 and out_ready=0.
- flush=1: output stage and skid cleared next edge; out_valid=0; any same-cycle input is discarded; in_ready=1 next cycle.

Optional Feature:
Macro DECODE_ILLEGAL_CNT_EN. When defined: extra output illegal_cnt [15:0], saturating at 16'hFFFF, increments once per illegal entry transferred on the output handshake; cleared only by reset (not flush). When undefined: port and logic absent.

Test Plan:
- Reset, stream 00E0,00EE,1234,6A5F,D125 with out_ready=1 -> one per cycle, decode 1,2,3,8,23; addr_out 0x234; x=A,val=5F; x=1,y=2,nib=5.
- 8120,C3F0 -> decode 10 with y=2; decode 22 with x=3,val=F0.
- out_ready=0 for 3 cycles while feeding 7105,7206,7307 -> in_ready drops after 2 accepts; release -> 7105,7206,7307 in order, none lost.
- flush during stall with 2 entries held -> out_valid=0 next cycle; next input emerges alone.
- SCHIP=0: 00FF -> 31, F075 -> illegal; SCHIP=1: 00FF -> 41, F075 -> 44, D120 -> 42.
- With DECODE_ILLEGAL_CNT_EN: feed 5121, E1FF, 8F0F -> illegal=1 each, illegal_cnt=3.
